// File: rtl/spi_dac_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// spi_dac_scheduler_pkg
// Shared types for the SPI DAC scheduler: FSM state encoding, channel-select
// constants and the DAC power-state encodings.
// -----------------------------------------------------------------------------
package spi_dac_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Channel identifier; also the value placed in the word's channel bit.
   typedef enum logic {
      CH_A = 1'b0,
      CH_B = 1'b1
   } ch_t;

   // DAC power-down modes as carried to spi_main.
   typedef enum logic [1:0] {
      PWR_ON       = 2'b00,
      PWR_OFF_1K   = 2'b01,
      PWR_OFF_100K = 2'b10,
      PWR_OFF_HIZ  = 2'b11
   } pwr_t;

   // Width of the csb-edge wait counter.
   localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/spi_dac_scheduler_if.sv
// -----------------------------------------------------------------------------
// spi_dac_scheduler_if
// Link between the scheduler and spi_main.
//   load        : start strobe to spi_main
//   parallel_in : word to shift out
//   power_state : DAC power mode
//   csb         : spi_main chip select, low while a frame is in progress
// master = scheduler side, slave = spi_main side.
// -----------------------------------------------------------------------------
interface spi_dac_scheduler_if
   import spi_dac_scheduler_pkg::*;
#(
   parameter int WORD_WIDTH = 16
);
   logic                  load;
   logic [WORD_WIDTH-1:0] parallel_in;
   pwr_t                  power_state;
   logic                  csb;

   modport master (output load, output parallel_in, output power_state, input csb);
   modport slave  (input load, input parallel_in, input power_state, output csb);
endinterface

// File: rtl/spi_dac_scheduler_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. On a tie the channel not granted last wins.
//   req_a, req_b : requests
//   last_grant   : channel granted most recently
//   grant_valid  : at least one request is present
//   grant_sel    : winning channel (meaningful only with grant_valid)
// -----------------------------------------------------------------------------
module rr_arb2
   import spi_dac_scheduler_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  ch_t  last_grant,
   output logic grant_valid,
   output ch_t  grant_sel
);

   assign grant_valid = req_a | req_b;

   assign grant_sel = (req_a && req_b) ? ((last_grant == CH_A) ? CH_B : CH_A) :
                      (req_a           ? CH_A : CH_B);

endmodule

// File: rtl/spi_dac_scheduler.sv
// -----------------------------------------------------------------------------
// spi_dac_scheduler
// Arbitrates two DAC sample requesters onto one spi_main, building one SPI word
// per grant and sequencing a single frame with a csb-edge timeout.
//   sys_clk, rst_n   : clock, asynchronous active-low reset
//   req_x, data_x    : channel request and sample (x = a, b)
//   ack_x            : one-cycle completion pulse for channel x
//   pwr_cfg          : requested power mode, taken only while idle
//   spi              : link to spi_main (load, parallel_in, power_state, csb)
//   timeout_err      : one-cycle pulse when a csb wait times out
//   busy             : high whenever a transfer is in flight
// -----------------------------------------------------------------------------
module spi_dac_scheduler
   import spi_dac_scheduler_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int DATA_WIDTH = 12,
   parameter int TIMEOUT    = 255
)(
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    req_a,
   input  logic [DATA_WIDTH-1:0]   data_a,
   output logic                    ack_a,
   input  logic                    req_b,
   input  logic [DATA_WIDTH-1:0]   data_b,
   output logic                    ack_b,
   input  logic [1:0]              pwr_cfg,
   spi_dac_scheduler_if.master     spi,
   output logic                    timeout_err,
   output logic                    busy
);

   // Counter value of the last cycle allowed in LOAD or SHIFT.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   ch_t                    last_grant_q, cur_ch_q;
   logic [WORD_WIDTH-1:0]  word_q, word_next;
   pwr_t                   pwr_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   to_q, timeout_hit;
   logic                   grant_valid;
   ch_t                    grant_sel;

   rr_arb2 u_arb (
      .req_a       (req_a),
      .req_b       (req_b),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );

   // Word layout: zero padding, channel bit, sample.
   always_comb begin
      word_next                 = '0;
      word_next[DATA_WIDTH]     = grant_sel;
      word_next[DATA_WIDTH-1:0] = (grant_sel == CH_A) ? data_a : data_b;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (grant_valid) state_d = ST_LOAD;
         ST_LOAD: begin
            if (!spi.csb) begin
               state_d = ST_SHIFT;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               timeout_hit = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (spi.csb) begin
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               timeout_hit = 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register here samples the
   // pre-edge value of every other, independent of statement order.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= CH_B;
         cur_ch_q     <= CH_A;
         word_q       <= '0;
         pwr_q        <= PWR_ON;
         cnt_q        <= '0;
         to_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= timeout_hit;

         // Any state change restarts the wait; it only advances while
         // waiting on a csb edge.
         if (state_q != state_d) begin
            cnt_q <= '0;
         end else if (state_q == ST_LOAD || state_q == ST_SHIFT) begin
            cnt_q <= cnt_q + 1'b1;
         end

         // The word is captured at grant and then frozen until the next grant;
         // power mode only moves in an idle cycle that grants nothing.
         if (state_q == ST_IDLE) begin
            if (grant_valid) begin
               word_q       <= word_next;
               cur_ch_q     <= grant_sel;
               last_grant_q <= grant_sel;
            end else begin
               pwr_q <= pwr_t'(pwr_cfg);
            end
         end
      end
   end

   assign spi.load        = (state_q == ST_LOAD);
   assign spi.parallel_in = word_q;
   assign spi.power_state = pwr_q;
   assign ack_a           = (state_q == ST_DONE) && (cur_ch_q == CH_A);
   assign ack_b           = (state_q == ST_DONE) && (cur_ch_q == CH_B);
   assign timeout_err     = to_q;
   assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_dac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_dac_scheduler
// Self-checking bench: a spi_main responder model drives csb, a transaction
// level model predicts grant order, words and power state.
// -----------------------------------------------------------------------------
module tb_spi_dac_scheduler;
   import spi_dac_scheduler_pkg::*;

   localparam int WW = 16;
   localparam int DW = 12;

   logic          sys_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          req_a   = 1'b0;
   logic          req_b   = 1'b0;
   logic [DW-1:0] data_a  = '0;
   logic [DW-1:0] data_b  = '0;
   logic [1:0]    pwr_cfg = 2'b00;
   logic          ack_a, ack_b, timeout_err, busy;

   // Second instance with a short timeout and csb never driven low.
   logic          req_t   = 1'b0;
   logic [DW-1:0] data_t  = '0;
   logic          req_tb  = 1'b0;
   logic [DW-1:0] data_tb = '0;
   logic [1:0]    pwr_t_cfg = 2'b00;
   logic          ack_ta, ack_tb, to_t, busy_t;

   int   checks = 0;
   int   errors = 0;
   logic model_last;

   spi_dac_scheduler_if #(.WORD_WIDTH(WW)) spi ();
   spi_dac_scheduler_if #(.WORD_WIDTH(WW)) spi_t ();

   spi_dac_scheduler #(.WORD_WIDTH(WW), .DATA_WIDTH(DW), .TIMEOUT(255)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .req_a       (req_a),
      .data_a      (data_a),
      .ack_a       (ack_a),
      .req_b       (req_b),
      .data_b      (data_b),
      .ack_b       (ack_b),
      .pwr_cfg     (pwr_cfg),
      .spi         (spi.master),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   spi_dac_scheduler #(.WORD_WIDTH(WW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut_to (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .req_a       (req_t),
      .data_a      (data_t),
      .ack_a       (ack_ta),
      .req_b       (req_tb),
      .data_b      (data_tb),
      .ack_b       (ack_tb),
      .pwr_cfg     (pwr_t_cfg),
      .spi         (spi_t.master),
      .timeout_err (to_t),
      .busy        (busy_t)
   );

   always #5 sys_clk = ~sys_clk;

   initial spi_t.csb = 1'b1;

   // spi_main model: csb falls 2 cycles after load is seen, rises 17 later.
   initial begin
      spi.csb = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (spi.load === 1'b1) begin
            @(posedge sys_clk);
            @(posedge sys_clk);
            #1 spi.csb = 1'b0;
            repeat (17) @(posedge sys_clk);
            #1 spi.csb = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Round-robin rule: on a tie the channel not served last wins.
   function automatic logic pick(input logic ra, input logic rb, input logic last);
      if (ra && rb) return ~last;
      return ra ? CH_A : CH_B;
   endfunction

   task automatic check_reset_outputs();
      check("rst_load",   spi.load,        0);
      check("rst_word",   spi.parallel_in, 0);
      check("rst_pwr",    spi.power_state, 0);
      check("rst_ack_a",  ack_a,           0);
      check("rst_ack_b",  ack_b,           0);
      check("rst_to",     timeout_err,     0);
      check("rst_busy",   busy,            0);
   endtask

   // Follows one transfer on the main instance and compares it with the
   // expected channel/sample. drop_mode: 0 drop acked req, 1 keep, 2 drop all.
   task automatic serve(input logic exp_ch, input logic [DW-1:0] exp_data,
                        input int drop_mode, input bit early_drop, input bit pwr_flip);
      logic [WW-1:0] exp_word, word0;
      logic [1:0]    ps0;
      logic          got_ch;
      int            load_cyc, both_ack, unstable, ps_moves, to_seen, rise_cyc, ack_cyc;
      bit            started, shifted, got_ack, flipped;
      load_cyc = 0; both_ack = 0; unstable = 0; ps_moves = 0; to_seen = 0;
      rise_cyc = -1; ack_cyc = -1;
      started = 0; shifted = 0; got_ack = 0; flipped = 0;
      word0 = '0; ps0 = '0; got_ch = 1'b0;
      exp_word = (exp_ch == CH_B) ? (16'h1000 + 16'(exp_data)) : 16'(exp_data);

      for (int cyc = 0; cyc < 300 && !got_ack; cyc++) begin
         @(negedge sys_clk);
         if (busy && !started) begin
            started = 1;
            word0   = spi.parallel_in;
            ps0     = spi.power_state;
            // Sample changes and request drops after grant must not matter.
            if (exp_ch == CH_A) data_a = DW'($urandom); else data_b = DW'($urandom);
            if (early_drop) begin
               if (exp_ch == CH_A) req_a = 1'b0; else req_b = 1'b0;
            end
         end
         if (busy) begin
            if (spi.parallel_in !== word0) unstable++;
            if (spi.power_state !== ps0)   ps_moves++;
         end
         if (spi.load) load_cyc++;
         if (busy && !spi.csb) shifted = 1;
         if (shifted && spi.csb && rise_cyc < 0) rise_cyc = cyc;
         if (pwr_flip && shifted && !spi.load && !flipped) begin
            flipped = 1;
            pwr_cfg = 2'b01;
         end
         if (timeout_err) to_seen++;
         if (ack_a && ack_b) both_ack++;
         if (ack_a || ack_b) begin
            got_ack = 1;
            got_ch  = ack_b;
            ack_cyc = cyc;
            case (drop_mode)
               0: if (ack_b) req_b = 1'b0; else req_a = 1'b0;
               2: begin req_a = 1'b0; req_b = 1'b0; end
               default: ;
            endcase
         end
      end

      if (!got_ack) begin
         check("ack_wait", 0, 1);
         req_a = 1'b0;
         req_b = 1'b0;
         repeat (30) @(negedge sys_clk);
         return;
      end

      check("chan",        got_ch,            exp_ch);
      check("word",        word0,             exp_word);
      check("load_cycles", load_cyc,          3);
      check("word_stable", unstable,          0);
      check("pwr_stable",  ps_moves,          0);
      check("ack_onehot",  both_ack,          0);
      check("no_timeout",  to_seen,           0);
      check("ack_delay",   ack_cyc - rise_cyc, 1);
      @(negedge sys_clk);
      check("idle_busy",   busy,              0);
      check("ack_pulse",   ack_a | ack_b,     0);
      model_last = exp_ch;
   endtask

   task automatic run_timeout();
      logic [WW-1:0] word0;
      int  loads;
      bit  found, seen_load;
      loads = 0; found = 0; seen_load = 0; word0 = '0;
      @(negedge sys_clk);
      req_t  = 1'b1;
      data_t = DW'($urandom);
      for (int cyc = 0; cyc < 60 && !found; cyc++) begin
         @(negedge sys_clk);
         if (spi_t.load) begin
            loads++;
            if (!seen_load) begin
               seen_load = 1;
               word0 = spi_t.parallel_in;
            end
         end
         if (ack_ta || to_t) begin
            found = 1;
            check("to_pulse", to_t,   1);
            check("to_ack",   ack_ta, 1);
            req_t = 1'b0;
         end
      end
      if (!found) begin
         check("to_wait", 0, 1);
         req_t = 1'b0;
      end
      check("to_loads", loads, 8);
      check("to_word",  word0, 16'(data_t));
      @(negedge sys_clk);
      check("to_idle",  busy_t, 0);
      check("to_once",  to_t,   0);
   endtask

   task automatic run_reset_mid_shift();
      bit found;
      int acks;
      found = 0; acks = 0;
      @(negedge sys_clk);
      req_a  = 1'b1;
      data_a = DW'($urandom);
      for (int cyc = 0; cyc < 60 && !found; cyc++) begin
         @(negedge sys_clk);
         if (busy && !spi.load && !spi.csb) found = 1;
      end
      check("reach_shift", found, 1);
      repeat (3) @(negedge sys_clk);
      #2 rst_n = 1'b0;
      req_a = 1'b0;
      #1 check_reset_outputs();
      repeat (20) begin
         @(negedge sys_clk);
         if (ack_a || ack_b) acks++;
      end
      rst_n = 1'b1;
      model_last = CH_B;
      @(negedge sys_clk);
      check("post_rst_idle", busy, 0);
      repeat (4) begin
         @(negedge sys_clk);
         if (ack_a || ack_b) acks++;
      end
      check("rst_no_ack", acks, 0);
      req_a  = 1'b1;
      data_a = DW'($urandom);
      serve(CH_A, data_a, 0, 0, 0);
   endtask

   initial begin
      logic e;
      int   pat;
      bit   ra, rb, early;

      // Reset with both requesters already asking.
      rst_n   = 1'b0;
      req_a   = 1'b1;
      req_b   = 1'b1;
      data_a  = DW'($urandom);
      data_b  = 12'h0D8;
      pwr_cfg = 2'b10;
      repeat (3) @(negedge sys_clk);
      check_reset_outputs();
      check("rst_busy_t", busy_t, 0);
      rst_n      = 1'b1;
      model_last = CH_B;

      // Simultaneous requests: A first, then B.
      for (int i = 0; i < 2; i++) begin
         e = pick(req_a, req_b, model_last);
         serve(e, e ? data_b : data_a, 0, 0, 0);
      end

      // Single request with the reference sample.
      req_a  = 1'b1;
      data_a = 12'h5A5;
      serve(CH_A, 12'h5A5, 0, 0, 0);

      // Both held high: grants must alternate.
      req_a  = 1'b1;
      req_b  = 1'b1;
      data_a = DW'($urandom);
      data_b = DW'($urandom);
      for (int i = 0; i < 4; i++) begin
         e = pick(req_a, req_b, model_last);
         serve(e, e ? data_b : data_a, (i == 3) ? 2 : 1, 0, 0);
      end

      // Power change during SHIFT only lands once idle.
      pwr_cfg = 2'b11;
      repeat (3) @(negedge sys_clk);
      check("pwr_idle", spi.power_state, 2'b11);
      req_a  = 1'b1;
      data_a = DW'($urandom);
      serve(CH_A, data_a, 0, 0, 1);
      check("pwr_hold", spi.power_state, 2'b11);
      @(negedge sys_clk);
      check("pwr_update", spi.power_state, 2'b01);

      run_timeout();
      run_reset_mid_shift();

      // Randomized request patterns, samples and power modes.
      for (int i = 0; i < 10; i++) begin
         pwr_cfg = 2'($urandom);
         repeat (2) @(negedge sys_clk);
         check("pwr_rand", spi.power_state, pwr_cfg);
         pat    = $urandom_range(1, 3);
         ra     = pat[0];
         rb     = pat[1];
         data_a = DW'($urandom);
         data_b = DW'($urandom);
         req_a  = ra;
         req_b  = rb;
         early  = 1'($urandom_range(0, 1));
         e = pick(req_a, req_b, model_last);
         serve(e, e ? data_b : data_a, 0, early, 0);
         if (ra && rb) begin
            e = pick(req_a, req_b, model_last);
            serve(e, e ? data_b : data_a, 0, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
